// File: rtl/frame_seq_pkg.sv
// Shared encodings, header constants and header helpers for frame_sequencer.
package frame_seq_pkg;

  localparam int unsigned HDR_W   = 32;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned BAD_W   = 8;

  localparam logic [STATE_W-1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN_ENC     = 2'd1;
  localparam logic [STATE_W-1:0] ST_TIMEOUT_ENC = 2'd2;
  localparam logic [STATE_W-1:0] ST_ESTOP_ENC   = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_RUN     = ST_RUN_ENC,
    ST_TIMEOUT = ST_TIMEOUT_ENC,
    ST_ESTOP   = ST_ESTOP_ENC
  } seq_state_e;

  localparam logic [HDR_W-1:0] HDR_WRITE = 32'h74697277;  // "writ"
  localparam logic [HDR_W-1:0] HDR_READ  = 32'h64616572;  // "read"
  localparam logic [HDR_W-1:0] HDR_DATA  = 32'h64617461;  // "data"
  localparam logic [HDR_W-1:0] HDR_ESTP  = 32'h65737470;  // "estp"

  typedef enum logic [1:0] {
    FR_NONE,
    FR_WRITE,
    FR_READ,
    FR_BAD
  } frame_class_e;

  // Header arrives byte-swapped in the top word of the frame.
  function automatic logic [HDR_W-1:0] unswap_header(input logic [HDR_W-1:0] raw);
    return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
  endfunction

  function automatic frame_class_e classify(input logic valid, input logic [HDR_W-1:0] hdr);
    frame_class_e fc;
    if (!valid)                 fc = FR_NONE;
    else if (hdr == HDR_WRITE)  fc = FR_WRITE;
    else if (hdr == HDR_READ)   fc = FR_READ;
    else                        fc = FR_BAD;
    return fc;
  endfunction

endpackage

// File: rtl/frame_sequencer_watchdog_timer.sv
// Up-counter with synchronous clear and enable; tc_c strobes on the last count
// before wrap. Shared by the host-link watchdog and the ESTOP debouncer.
module watchdog_timer #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  logic [CNT_W-1:0] count_q;

  // Clear outranks the terminal strobe so a restart never reports expiry.
  assign tc_c = enable && !clear && (count_q == CNT_W'(MAX_COUNT - 1));

  always_ff @(posedge sysclk) begin
    if (!rst_n || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tc_c ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// SPI frame sequencer: header check, command latch, link watchdog, ESTOP latch.
// Optional macro FRAME_SEQ_ESTOP_DEBOUNCE_EN adds a stability filter on estop_in.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE     = 240,
  parameter int unsigned TIMEOUT_CYCLES  = 4800000,
  parameter int unsigned DEBOUNCE_CYCLES = 48000
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   pkg_done,
  input  logic [BUFFER_SIZE-1:0] rx_frame,
  input  logic                   estop_in,
  output logic [BUFFER_SIZE-1:0] cmd_data,
  output logic                   cmd_valid,
  output logic [HDR_W-1:0]       header_tx,
  output logic                   fault,
  output logic [STATE_W-1:0]     state,
  output logic [BAD_W-1:0]       bad_frames
);

  if (TIMEOUT_CYCLES < 2 || DEBOUNCE_CYCLES < 2 || BUFFER_SIZE < HDR_W) begin : g_param_check
    $error("frame_sequencer: unsupported parameter values");
  end

  seq_state_e             state_q;
  seq_state_e             state_d;
  logic [BUFFER_SIZE-1:0] cmd_data_d;
  logic                   cmd_valid_d;
  logic [HDR_W-1:0]       header_d;
  logic                   fault_d;
  logic [BAD_W-1:0]       bad_d;
  frame_class_e           fclass_c;
  logic [1:0]             estop_sync_q;
  logic                   estop_act;
  logic                   wd_clear;
  logic                   wd_en;
  logic                   wd_tc_c;

  assign fclass_c = classify(pkg_done, unswap_header(rx_frame[BUFFER_SIZE-1 -: HDR_W]));
  assign state    = state_q;

  // Two-flop synchroniser for the asynchronous estop input.
  always_ff @(posedge sysclk) begin
    if (!rst_n) estop_sync_q <= '0;
    else        estop_sync_q <= {estop_sync_q[0], estop_in};
  end

`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
  logic estop_db_q;
  logic db_diff;
  logic db_tc_c;

  assign db_diff = (estop_sync_q[1] != estop_db_q);

  // Any return to the current level restarts the stability window.
  watchdog_timer #(
    .MAX_COUNT(DEBOUNCE_CYCLES)
  ) u_debounce (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .clear (!db_diff),
    .enable(db_diff),
    .tc_c  (db_tc_c)
  );

  always_ff @(posedge sysclk) begin
    if (!rst_n)       estop_db_q <= 1'b0;
    else if (db_tc_c) estop_db_q <= estop_sync_q[1];
  end

  assign estop_act = estop_db_q;
`else
  assign estop_act = estop_sync_q[1];
`endif

  // Any recognised frame is proof of life; outside RUN the watchdog is held at zero.
  assign wd_en    = (state_q == ST_RUN);
  assign wd_clear = (fclass_c == FR_WRITE) || (fclass_c == FR_READ) || !wd_en;

  watchdog_timer #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .clear (wd_clear),
    .enable(wd_en),
    .tc_c  (wd_tc_c)
  );

  // Next state and next output values; ESTOP > WRITE > watchdog expiry.
  always_comb begin
    state_d     = state_q;
    cmd_data_d  = cmd_data;
    cmd_valid_d = 1'b0;
    bad_d       = bad_frames;

    if (fclass_c == FR_BAD && bad_frames != {BAD_W{1'b1}}) begin
      bad_d = bad_frames + BAD_W'(1);
    end

    if (estop_act) begin
      state_d    = ST_ESTOP;
      cmd_data_d = '0;
    end else if (fclass_c == FR_WRITE) begin
      state_d     = ST_RUN;
      cmd_data_d  = rx_frame;
      cmd_valid_d = 1'b1;
    end else if (state_q == ST_RUN && wd_tc_c) begin
      state_d    = ST_TIMEOUT;
      cmd_data_d = '0;
    end

    header_d = (state_d == ST_ESTOP) ? HDR_ESTP : HDR_DATA;
    fault_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_data   <= '0;
      cmd_valid  <= 1'b0;
      header_tx  <= HDR_DATA;
      fault      <= 1'b1;
      bad_frames <= '0;
    end else begin
      state_q    <= state_d;
      cmd_data   <= cmd_data_d;
      cmd_valid  <= cmd_valid_d;
      header_tx  <= header_d;
      fault      <= fault_d;
      bad_frames <= bad_d;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model. Honors FRAME_SEQ_ESTOP_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int unsigned B = 240;
  localparam int unsigned T = 40;
  localparam int unsigned D = 6;
`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
  localparam int EST_LAT = 2 + int'(D);
`else
  localparam int EST_LAT = 2;
`endif

  localparam logic [31:0] W_HDR  = 32'h74697277;
  localparam logic [31:0] R_HDR  = 32'h64616572;
  localparam logic [31:0] D_HDR  = 32'h64617461;
  localparam logic [31:0] E_HDR  = 32'h65737470;
  localparam logic [31:0] BAD_HD = 32'hDEADBEEF;

  logic         sysclk   = 1'b0;
  logic         rst_n    = 1'b0;
  logic         pkg_done = 1'b0;
  logic         estop_in = 1'b0;
  logic [B-1:0] rx_frame = '0;

  logic [B-1:0] cmd_data;
  logic         cmd_valid;
  logic [31:0]  header_tx;
  logic         fault;
  logic [1:0]   state;
  logic [7:0]   bad_frames;

  frame_sequencer #(
    .BUFFER_SIZE    (B),
    .TIMEOUT_CYCLES (T),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .pkg_done  (pkg_done),
    .rx_frame  (rx_frame),
    .estop_in  (estop_in),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .header_tx (header_tx),
    .fault     (fault),
    .state     (state),
    .bad_frames(bad_frames)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: states 0 idle, 1 run, 2 timeout, 3 estop.
  int           m_state;
  logic [B-1:0] m_cmd;
  logic         m_valid;
  int           m_bad;
  int           quiet;
  logic         e1, e2;
`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
  logic         m_act;
  int           db_run;
`endif

  always @(posedge sysclk) begin : model
    logic [31:0] h;
    logic        wr, rd, act;
    if (!rst_n) begin
      m_state = 0; m_cmd = '0; m_valid = 1'b0; m_bad = 0; quiet = 0;
      e1 = 1'b0; e2 = 1'b0;
`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
      m_act = 1'b0; db_run = 0;
`endif
    end else begin
      h  = {rx_frame[B-25 -: 8], rx_frame[B-17 -: 8], rx_frame[B-9 -: 8], rx_frame[B-1 -: 8]};
      wr = pkg_done && (h == W_HDR);
      rd = pkg_done && (h == R_HDR);
`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
      act = m_act;
      if (e2 != m_act) begin
        db_run++;
        if (db_run == int'(D)) begin m_act = e2; db_run = 0; end
      end else begin
        db_run = 0;
      end
`else
      act = e2;
`endif
      e2 = e1;
      e1 = estop_in;
      m_valid = 1'b0;
      if (pkg_done && !wr && !rd && m_bad < 255) m_bad++;
      if (wr || rd) quiet = 0;
      else if (m_state == 1) quiet++;
      if (act) begin
        m_state = 3; m_cmd = '0;
      end else if (wr) begin
        m_state = 1; m_cmd = rx_frame; m_valid = 1'b1;
      end else if (m_state == 1 && quiet == int'(T)) begin
        m_state = 2; m_cmd = '0;
      end
    end
  end

  always @(negedge sysclk) begin
    if (chk_en) begin
      check("state",      256'(state),      256'(m_state[1:0]));
      check("fault",      256'(fault),      256'(m_state != 1));
      check("header_tx",  256'(header_tx),  256'((m_state == 3) ? E_HDR : D_HDR));
      check("cmd_valid",  256'(cmd_valid),  256'(m_valid));
      check("cmd_data",   256'(cmd_data),   256'(m_cmd));
      check("bad_frames", 256'(bad_frames), 256'(m_bad[7:0]));
    end
  end

  function automatic logic [B-1:0] rnd_bits();
    logic [B-1:0] f;
    for (int i = 0; i < int'(B); i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  function automatic logic [B-1:0] mk(input logic [31:0] hdr, input logic [31:0] j0);
    logic [B-1:0] f;
    f = rnd_bits();
    f[B-1 -: 32]  = {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24]};
    f[B-33 -: 32] = j0;
    return f;
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #2;
  endtask

  task automatic send(input logic [B-1:0] f);
    pkg_done = 1'b1;
    rx_frame = f;
    tick();
    pkg_done = 1'b0;
    rx_frame = rnd_bits();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [B-1:0] f;
    int           kind;
    int           rate;

    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_state", 256'(state), 256'(0));
    check("rst_fault", 256'(fault), 256'(1));
    check("rst_hdr",   256'(header_tx), 256'(D_HDR));
    check("rst_cmd",   256'(cmd_data), 256'(0));
    check("rst_bad",   256'(bad_frames), 256'(0));
    rst_n = 1'b1;
    tick();

    // Write then silence until timeout, then recover.
    send(mk(W_HDR, 32'h00001000));
    check("t1_valid", 256'(cmd_valid), 256'(1));
    check("t1_state", 256'(state), 256'(1));
    check("t1_fault", 256'(fault), 256'(0));
    check("t1_j0",    256'(cmd_data[B-33 -: 32]), 256'(32'h00001000));
    tick();
    check("t1_pulse", 256'(cmd_valid), 256'(0));
    idle(int'(T) - 2);
    check("t2_last_run", 256'(state), 256'(1));
    tick();
    check("t2_timeout", 256'(state), 256'(2));
    check("t2_cmd0",    256'(cmd_data), 256'(0));
    check("t2_fault",   256'(fault), 256'(1));
    f = mk(W_HDR, 32'h00002000);
    send(f);
    check("t2_recover", 256'(state), 256'(1));

    // Bad headers neither latch nor feed the watchdog.
    for (int i = 0; i < 3; i++) send(mk(BAD_HD, 32'h0BAD0BAD));
    check("t3_bad3", 256'(bad_frames), 256'(3));
    check("t3_keep", 256'(cmd_data), 256'(f));
    idle(int'(T) - 4);
    check("t3_run", 256'(state), 256'(1));
    tick();
    check("t3_timeout", 256'(state), 256'(2));

    // ESTOP outranks a write, needs release plus a write to exit.
    send(mk(W_HDR, 32'h00003000));
    estop_in = 1'b1;
    idle(EST_LAT);
    send(mk(W_HDR, 32'h00004000));
    check("t4_drop",  256'(cmd_valid), 256'(0));
    check("t4_estop", 256'(state), 256'(3));
    check("t4_hdr",   256'(header_tx), 256'(E_HDR));
    check("t4_cmd0",  256'(cmd_data), 256'(0));
    estop_in = 1'b0;
    idle(EST_LAT);
    send(mk(R_HDR, 32'h0));
    check("t4_read_stay", 256'(state), 256'(3));
    check("t4_read_hdr",  256'(header_tx), 256'(E_HDR));
    f = mk(W_HDR, 32'h00005000);
    send(f);
    check("t4_exit",     256'(state), 256'(1));
    check("t4_exit_hdr", 256'(header_tx), 256'(D_HDR));
    check("t4_latch",    256'(cmd_data), 256'(f));

    // Reads only keep IDLE; bad counter saturates.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin send(mk(R_HDR, 32'h1)); tick(); end
    check("t5_idle", 256'(state), 256'(0));
    check("t5_cmd0", 256'(cmd_data), 256'(0));
    for (int i = 0; i < 300; i++) send(mk(BAD_HD, 32'h2));
    check("t5_sat", 256'(bad_frames), 256'(255));

`ifdef FRAME_SEQ_ESTOP_DEBOUNCE_EN
    // Short glitch is filtered, a held level gets through.
    send(mk(W_HDR, 32'h00006000));
    estop_in = 1'b1;
    idle(int'(D) - 3);
    estop_in = 1'b0;
    idle(int'(D) + 6);
    check("t6_glitch", 256'(state), 256'(1));
    estop_in = 1'b1;
    idle(EST_LAT + 1);
    check("t6_held", 256'(state), 256'(3));
    estop_in = 1'b0;
    idle(EST_LAT + 1);
`endif

    // Random traffic with busy and sparse phases.
    for (int i = 0; i < 4000; i++) begin
      rate = ((i / 400) % 2 == 1) ? 60 : 3;
      if ($urandom_range(0, rate - 1) == 0) begin
        pkg_done = 1'b1;
        kind = int'($urandom_range(0, 99));
        if (kind < 45)      rx_frame = mk(W_HDR, $urandom);
        else if (kind < 70) rx_frame = mk(R_HDR, $urandom);
        else if (kind < 85) rx_frame = mk(BAD_HD, $urandom);
        else                rx_frame = rnd_bits();
      end else begin
        pkg_done = 1'b0;
        rx_frame = rnd_bits();
      end
      if (estop_in) estop_in = ($urandom_range(0, 19) != 0);
      else          estop_in = ($urandom_range(0, 299) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      tick();
    end
    pkg_done = 1'b0;
    estop_in = 1'b0;
    rst_n    = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
